spi_slave_if: RTL and testbench

Serial front end of the SPI slave. It deserialises MOSI frames into 10-bit words for the downstream memory block, which takes them on rx_data/rx_valid. It also serialises that block's 8-bit read response (tx_data/tx_valid) back onto MISO. A five-state FSM runs on the SPI serial clock and tracks whether a read address has been loaded.

---
 rtl/spi_slave_if.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_if.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI slave serial front end: deserialises MOSI frames into FRAME_W-bit words
// and serialises the memory block's TX_W-bit read response onto MISO.
// All logic runs on the SPI serial clock with a synchronous active-low reset.
// Optional build macro SPI_CMD_CHECK_EN: when defined, the two command bits of
// each completed frame must agree with the path chosen by the first bit, and
// mismatching frames are dropped silently.

module spi_slave_if #(
    parameter int unsigned FRAME_W = 10,
    parameter int unsigned TX_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    input  logic [TX_W-1:0]    tx_data,
    input  logic               tx_valid,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid
);

    localparam int unsigned CntW   = $clog2(FRAME_W + 1);
    localparam int unsigned TxCntW = $clog2(TX_W + 1);

    localparam logic [CntW-1:0]   FrameLast = CntW'(FRAME_W - 1);
    localparam logic [CntW-1:0]   FrameFull = CntW'(FRAME_W);
    localparam logic [TxCntW-1:0] TxFull    = TxCntW'(TX_W);

    typedef enum logic [2:0] {
        StIdle,
        StChkCmd,
        StWrite,
        StReadAdd,
        StReadData
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0]  shift_q, shift_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rd_pend_q, rd_pend_d;
    logic                tx_arm_q, tx_arm_d;
    logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [TX_W-1:0]     tx_shift_q, tx_shift_d;
    logic                miso_q, miso_d;

    logic [FRAME_W-1:0]  frame_word;
    logic                cmd_ok;

    // The word as it would look if the current MOSI bit is the last one.
    assign frame_word = {shift_q, MOSI};

`ifdef SPI_CMD_CHECK_EN
    // Command bits must agree with the path taken in CHK_CMD.
    always_comb begin
        cmd_ok = 1'b0;
        case (state_q)
            StWrite:    cmd_ok = ~frame_word[FRAME_W-1];
            StReadAdd:  cmd_ok = (frame_word[FRAME_W-1:FRAME_W-2] == 2'b10);
            StReadData: cmd_ok = (frame_word[FRAME_W-1:FRAME_W-2] == 2'b11);
            default:    cmd_ok = 1'b0;
        endcase
    end
`else
    assign cmd_ok = 1'b1;
`endif

    // Next-state logic for the FSM, receive shifter and read-response shifter.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rd_pend_d  = rd_pend_q;
        tx_arm_d   = tx_arm_q;
        tx_cnt_d   = tx_cnt_q;
        tx_shift_d = tx_shift_q;
        miso_d     = 1'b0;

        if (state_q != StIdle && SS_n) begin
            // Abort: partial frames and responses are discarded.
            state_d    = StIdle;
            bit_cnt_d  = '0;
            shift_d    = '0;
            tx_arm_d   = 1'b0;
            tx_cnt_d   = '0;
            tx_shift_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!SS_n) begin
                        state_d = StChkCmd;
                    end
                end

                StChkCmd: begin
                    if (!MOSI) begin
                        state_d = StWrite;
                    end else if (rd_pend_q) begin
                        state_d = StReadData;
                    end else begin
                        state_d = StReadAdd;
                    end
                end

                StWrite, StReadAdd, StReadData: begin
                    if (bit_cnt_q != FrameFull) begin
                        shift_d   = frame_word[FRAME_W-2:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == FrameLast && cmd_ok) begin
                            rx_data_d  = frame_word;
                            rx_valid_d = 1'b1;
                            if (state_q == StReadAdd) begin
                                rd_pend_d = 1'b1;
                            end
                            if (state_q == StReadData) begin
                                rd_pend_d = 1'b0;
                                tx_arm_d  = 1'b1;
                            end
                        end
                    end else if (tx_arm_q && tx_valid) begin
                        // Latch the single-cycle response pulse; MSB goes out now.
                        miso_d     = tx_data[TX_W-1];
                        tx_shift_d = {tx_data[TX_W-2:0], 1'b0};
                        tx_cnt_d   = TxCntW'(1);
                        tx_arm_d   = 1'b0;
                    end else if (tx_cnt_q != '0 && tx_cnt_q != TxFull) begin
                        miso_d     = tx_shift_q[TX_W-1];
                        tx_shift_d = {tx_shift_q[TX_W-2:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            tx_arm_q   <= 1'b0;
            tx_cnt_q   <= '0;
            tx_shift_q <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rd_pend_q  <= rd_pend_d;
            tx_arm_q   <= tx_arm_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_shift_q <= tx_shift_d;
            miso_q     <= miso_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a transaction-level model predicts
// rx_valid/rx_data/MISO after every edge, and directed frames pin the model
// with hand-computed literals. Honours SPI_CMD_CHECK_EN if defined.

module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    spi_slave_if #(
        .FRAME_W(10),
        .TX_W   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .MISO    (MISO),
        .rx_data (rx_data),
        .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 awaiting path bit, 2 receiving, 3 frame finished.
    int   m_phase = 0;
    bit   m_is_read, m_is_rd_data, m_pend, m_arm;
    int   m_nbits, m_word;
    bit   m_txq[$];
    logic exp_miso = 1'b0, exp_rx_valid = 1'b0;
    logic [9:0] exp_rx_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cmd_ok(input int word);
`ifdef SPI_CMD_CHECK_EN
        int top;
        top = word >> 8;
        if (!m_is_read) return top < 2;
        if (!m_is_rd_data) return top == 2;
        return top == 3;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_edge(input logic ss, input logic mosi, input logic txv,
                              input logic [7:0] txd);
        exp_rx_valid = 1'b0;
        exp_miso     = 1'b0;
        if (m_phase != 0 && ss) begin
            m_phase = 0;
            m_arm   = 1'b0;
            m_txq.delete();
        end else begin
            case (m_phase)
                0: if (!ss) m_phase = 1;
                1: begin
                    m_is_read    = mosi;
                    m_is_rd_data = mosi && m_pend;
                    m_nbits      = 0;
                    m_word       = 0;
                    m_phase      = 2;
                end
                2: begin
                    m_word = (m_word * 2 + int'(mosi)) % 1024;
                    m_nbits++;
                    if (m_nbits == 10) begin
                        m_phase = 3;
                        if (cmd_ok(m_word)) begin
                            exp_rx_data  = 10'(m_word);
                            exp_rx_valid = 1'b1;
                            if (m_is_rd_data) begin
                                m_pend = 1'b0;
                                m_arm  = 1'b1;
                            end else if (m_is_read) begin
                                m_pend = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (m_txq.size() > 0) begin
                        exp_miso = m_txq.pop_front();
                    end else if (m_arm && txv) begin
                        m_arm = 1'b0;
                        for (int i = 7; i >= 0; i--) m_txq.push_back(txd[i]);
                        exp_miso = m_txq.pop_front();
                    end
                end
            endcase
        end
    endtask

    // One clock edge with the given inputs; model advances right after it.
    task automatic cycle(input logic ss, input logic mosi, input logic txv,
                         input logic [7:0] txd);
        SS_n     = ss;
        MOSI     = mosi;
        tx_valid = txv;
        tx_data  = txd;
        @(posedge clk);
        #1;
        model_edge(ss, mosi, txv, txd);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        m_phase      = 0;
        m_pend       = 1'b0;
        m_arm        = 1'b0;
        m_txq.delete();
        exp_rx_data  = '0;
        exp_rx_valid = 1'b0;
        exp_miso     = 1'b0;
        rst_n        = 1'b1;
    endtask

    // SS_n low edge, path edge, then nbits data bits MSB first; SS_n stays low.
    task automatic send_frame(input logic path, input logic [9:0] word, input int nbits);
        logic [9:0] w;
        w = word;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, path, 1'b0, 8'h00);
        for (int i = 0; i < nbits; i++) cycle(1'b0, w[9 - i], 1'b0, 8'h00);
    endtask

    task automatic hold(input logic ss, input int n);
        for (int i = 0; i < n; i++) cycle(ss, 1'(i), 1'b0, 8'h00);
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_valid", 32'(rx_valid), 32'(exp_rx_valid));
            check("rx_data", 32'(rx_data), 32'(exp_rx_data));
            check("miso", 32'(MISO), 32'(exp_miso));
        end
    end

    initial begin
        logic [7:0] got;
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        do_reset();
        chk_en = 1'b1;
        check("reset_rx_data", 32'(rx_data), 32'h0);
        check("reset_miso", 32'(MISO), 32'h0);
        hold(1'b1, 2);

        // Write address frame.
        send_frame(1'b0, 10'h0A5, 10);
        check("write_rx_valid", 32'(rx_valid), 32'h1);
        check("write_rx_data", 32'(rx_data), 32'h0A5);
        hold(1'b0, 4);
        check("write_no_repeat", 32'(rx_valid), 32'h0);
        hold(1'b1, 2);

        // Write path with command bits 11: dropped only when checking is built in.
        send_frame(1'b0, 10'h3FF, 10);
`ifdef SPI_CMD_CHECK_EN
        check("cmdchk_rx_valid", 32'(rx_valid), 32'h0);
        check("cmdchk_rx_data", 32'(rx_data), 32'h0A5);
`else
        check("nochk_rx_valid", 32'(rx_valid), 32'h1);
        check("nochk_rx_data", 32'(rx_data), 32'h3FF);
`endif
        hold(1'b1, 2);

        // Reset in the middle of a write frame.
        send_frame(1'b0, 10'h155, 5);
        do_reset();
        check("midreset_rx_data", 32'(rx_data), 32'h0);
        check("midreset_rx_valid", 32'(rx_valid), 32'h0);
        check("midreset_miso", 32'(MISO), 32'h0);
        hold(1'b1, 2);

        // Read address, then read data with a C3 response.
        send_frame(1'b1, 10'h23C, 10);
        check("rdaddr_rx_data", 32'(rx_data), 32'h23C);
        hold(1'b1, 2);
        send_frame(1'b1, 10'h300, 10);
        check("rddata_rx_data", 32'(rx_data), 32'h300);
        cycle(1'b0, 1'b0, 1'b1, 8'hC3);
        got[7] = MISO;
        for (int i = 6; i >= 0; i--) begin
            cycle(1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0, 8'hFF);
            got[i] = MISO;
        end
        check("rddata_miso_seq", 32'(got), 32'hC3);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF);
        check("rddata_miso_after", 32'(MISO), 32'h0);
        hold(1'b0, 3);
        hold(1'b1, 2);

        // Abort a read-address frame after 4 data bits.
        send_frame(1'b1, 10'h2F0, 4);
        hold(1'b1, 2);
        check("abort_rx_data", 32'(rx_data), 32'h300);

        // Next read frame must be a read address: tx_valid is ignored.
        send_frame(1'b1, 10'h2A5, 10);
        check("rdaddr2_rx_data", 32'(rx_data), 32'h2A5);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF);
        check("rdaddr2_no_miso", 32'(MISO), 32'h0);
        hold(1'b0, 3);
        hold(1'b1, 2);

        // Read data with delayed response, truncated by SS_n high mid-shift.
        send_frame(1'b1, 10'h3C1, 10);
        hold(1'b0, 2);
        cycle(1'b0, 1'b0, 1'b1, 8'hAA);
        check("trunc_first_bit", 32'(MISO), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        check("trunc_second_bit", 32'(MISO), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        hold(1'b1, 3);
        check("trunc_miso_zero", 32'(MISO), 32'h0);

        // Pending flag is clear again: this read frame is a read address.
        send_frame(1'b1, 10'h211, 10);
        cycle(1'b0, 1'b0, 1'b1, 8'hFF);
        hold(1'b0, 2);
        hold(1'b1, 2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
